// File: rtl/interp_mult_bank.sv
// interp_mult_bank
// Builds and holds the multiples 1*E .. NUM_MULT*E of a signed pilot-difference
// step E for the channel-estimation interpolator. A single accumulator adder
// produces one new multiple per cycle after an accepted start; results that
// leave the signed OUT_W range are clamped and flagged (sticky until next start).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   one-cycle build request (ignored while busy)
//   clear      in   synchronous clear of all entries; aborts a build, beats start
//   e_in       in   signed step E, sampled on an accepted start
//   rd_idx     in   multiple to read (1..NUM_MULT); other values read 0
//   rd_data    out  entry rd_idx*E, combinational from the registers
//   mult_bus   out  all entries; entry k at [k*OUT_W-1:(k-1)*OUT_W]
//   valid_mask out  bit k-1 set once entry k has been written this run
//   busy       out  high while the table is being built
//   done       out  one-cycle pulse after the last entry is written
//   sat_flag   out  sticky saturation indicator since the last start
module interp_mult_bank #(
    parameter int unsigned IN_W     = 17,
    parameter int unsigned NUM_MULT = 6,
    parameter int unsigned OUT_W    = 20,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         clear,
    input  logic signed [IN_W-1:0]       e_in,
    input  logic [IDX_W-1:0]             rd_idx,
    output logic signed [OUT_W-1:0]      rd_data,
    output logic [NUM_MULT*OUT_W-1:0]    mult_bus,
    output logic [NUM_MULT-1:0]          valid_mask,
    output logic                         busy,
    output logic                         done,
    output logic                         sat_flag
);

    localparam int unsigned CNT_W = $clog2(NUM_MULT + 1);
    localparam logic signed [OUT_W-1:0] MAX_VAL = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_VAL = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e                  state_q, state_d;
    logic signed [OUT_W-1:0] entry_q [NUM_MULT];
    logic signed [OUT_W-1:0] entry_d [NUM_MULT];
    logic signed [OUT_W-1:0] e_q, e_d;
    logic signed [OUT_W-1:0] acc_q, acc_d;
    logic [NUM_MULT-1:0]     valid_q, valid_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    done_q, done_d;
    logic                    sat_q, sat_d;

    logic signed [OUT_W-1:0] e_ext;
    logic [OUT_W:0]          sum;
    logic                    sum_ovf;
    logic signed [OUT_W-1:0] sum_clamped;

    assign e_ext = OUT_W'(e_in);

    // One guard bit: overflow shows up as the top two bits disagreeing.
    assign sum     = {acc_q[OUT_W-1], acc_q} + {e_q[OUT_W-1], e_q};
    assign sum_ovf = sum[OUT_W] ^ sum[OUT_W-1];

    always_comb begin
        sum_clamped = sum[OUT_W-1:0];
        if (sum_ovf) begin
            sum_clamped = sum[OUT_W] ? MIN_VAL : MAX_VAL;
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        e_d     = e_q;
        acc_d   = acc_q;
        valid_d = valid_q;
        count_d = count_q;
        done_d  = 1'b0;
        sat_d   = sat_q;

        if (clear) begin
            for (int k = 0; k < NUM_MULT; k++) begin
                entry_d[k] = '0;
            end
            state_d = StIdle;
            e_d     = '0;
            acc_d   = '0;
            valid_d = '0;
            count_d = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        e_d        = e_ext;
                        entry_d[0] = e_ext;
                        acc_d      = e_ext;
                        valid_d    = NUM_MULT'(1);
                        sat_d      = 1'b0;
                        count_d    = CNT_W'(2);
                        state_d    = StAccum;
                    end
                end
                StAccum: begin
                    // count_q is the 1-based number of the entry written this cycle.
                    for (int k = 1; k < NUM_MULT; k++) begin
                        if (count_q == CNT_W'(k + 1)) begin
                            entry_d[k] = sum_clamped;
                            valid_d[k] = 1'b1;
                        end
                    end
                    acc_d   = sum_clamped;
                    count_d = count_q + CNT_W'(1);
                    if (sum_ovf) begin
                        sat_d = 1'b1;
                    end
                    if (count_q == CNT_W'(NUM_MULT)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            for (int k = 0; k < NUM_MULT; k++) begin
                entry_q[k] <= '0;
            end
            e_q     <= '0;
            acc_q   <= '0;
            valid_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            e_q     <= e_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            count_q <= count_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
        end
    end

    // Index 0 and indices above NUM_MULT match no entry and read as zero.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_MULT; k++) begin
            if (rd_idx == IDX_W'(k + 1)) begin
                rd_data = entry_q[k];
            end
        end
    end

    for (genvar g = 0; g < NUM_MULT; g++) begin : g_bus
        assign mult_bus[g*OUT_W +: OUT_W] = entry_q[g];
    end

    assign valid_mask = valid_q;
    assign busy       = (state_q == StAccum);
    assign done       = done_q;
    assign sat_flag   = sat_q;

endmodule

// File: doc/interp_mult_bank.md
Name: interp_mult_bank

Overview:
- Parametrised generation of the E/2E/5E holding registers used by the channel-estimation interpolator.
- Given a signed pilot-difference step E, the block sequentially builds and stores the multiples 1·E … NUM_MULT·E using one accumulator adder.
- Adds a start/busy/done handshake, per-entry valid flags, saturation with a sticky flag, synchronous clear, and an indexed read port.
- Feeds the interpolation datapath, which reads any k·E without its own multipliers.

Parameters:
- IN_W, 17, width of signed input step E.
- NUM_MULT, 6, number of stored multiples (entries k = 1..NUM_MULT), range 2..16.
- OUT_W, 20, width of each signed stored entry, OUT_W ≥ IN_W.
- IDX_W, 4, width of the read index; must satisfy 2^IDX_W > NUM_MULT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to build the table from e_in.
- clear  in  1  synchronous clear of all entries and abort.
- e_in  in  IN_W  signed step E, sampled only on an accepted start.
- rd_idx  in  IDX_W  multiple to read (1..NUM_MULT).
- rd_data  out  OUT_W  signed entry rd_idx·E (combinational from registers).
- mult_bus  out  NUM_MULT*OUT_W  all entries flattened; entry k occupies bits [k*OUT_W-1:(k-1)*OUT_W].
- valid_mask  out  NUM_MULT  bit k-1 set once entry k is written.
- busy  out  1  high while the table is being built.
- done  out  1  one-cycle pulse when entry NUM_MULT is written.
- sat_flag  out  1  sticky; set if any entry saturated since the last start.

Behaviour:
- Reset (rst low, async): all entries 0, valid_mask 0, busy 0, done 0, sat_flag 0, internal e_reg/acc 0, state IDLE.
- States: IDLE, ACCUM.
- IDLE:
  - start=1 is accepted: e_reg ← e_in; entry1 ← sign-extended e_in; acc ← e_in; valid_mask ← 1; sat_flag ← 0; count ← 2.
  - Move to ACCUM (or straight to done/IDLE if NUM_MULT=1; not allowed by range).
- ACCUM, each cycle:
  - sum = acc + e_reg, computed at OUT_W+1 bits.
  - If sum is outside the signed OUT_W range, clamp to +2^(OUT_W-1)-1 or -2^(OUT_W-1) and set sat_flag.
  - entry[count] ← clamped sum; acc ← clamped sum; valid_mask[count-1] ← 1; count++.
  - When count = NUM_MULT is written: done=1 for that cycle (registered, asserted the cycle after the write edge), then return to IDLE.
- Latency: start accepted at edge T → entry k written at edge T+k-1; done high in the cycle following edge T+NUM_MULT-1; busy high from the cycle after T until done deasserts.
- Handshake: start while busy is ignored (no restart, e_in not sampled). A new start in the cycle done is high is accepted (state already IDLE).
- Restart behaviour: entries from a prior run persist until overwritten. On a new accepted start, valid_mask reloads to 1, so stale entries read as invalid.
- clear=1:
  - Next edge: entries 0, valid_mask 0, sat_flag 0, state IDLE, no done pulse.
  - clear has priority over start and over an in-progress build.
- Read port:
  - rd_data = entry[rd_idx] for rd_idx in 1..NUM_MULT.
  - rd_idx = 0 or rd_idx > NUM_MULT returns 0.
  - Read is independent of valid_mask; the consumer gates on valid_mask.
- Width rules: all arithmetic is two's-complement signed. e_in is sign-extended to OUT_W. No truncation: saturation only.
- Reset mid-build: immediate return to reset values; the build is not resumed.

Test Plan:
- Defaults, e_in=100, start one cycle → entries 100,200,300,400,500,600 written on successive edges; done pulses once 6 cycles after start; valid_mask steps 000001→111111; sat_flag 0.
- e_in=-3 → entries -3,-6,-9,-12,-15,-18; rd_idx=5 gives -15; rd_idx=0 and rd_idx=7 give 0.
- OUT_W=18, e_in=65535 → entry1=65535, entry2=131070, entries3..6=131071; sat_flag=1. Symmetric run with e_in=-65536 → entries3..6=-131072.
- start re-pulsed on cycle 3 of a build with e_in=7 (build started with e_in=10) → ignored; final entries 10..60, single done pulse.
- clear asserted on cycle 4 of a build together with start → next edge all entries 0, valid_mask 0, busy 0, no done, start not accepted.
- rst driven low mid-build at an asynchronous point → outputs zero immediately; after release, start with e_in=1 → entries 1..6 and a normal done.
